// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, defaults and byte-merge helper for ram_port_arbiter
package ram_arb_pkg;

    typedef enum logic {ARB, RMW_WR} state_t;

    localparam int unsigned MEM_WORDS_DEF = 1024;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

    // Take new_w bytes where be is set, keep old_w bytes elsewhere
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] m;
        for (int n = 0; n < 4; n++) m[8*n +: 8] = be[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
        return m;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between fetch and data ports; RAM_ARB_RR_EN selects round-robin instead of data-first priority
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_di_o,
    input  logic [31:0] ram_dout_i,
    output logic        err_o
);

    state_t      r_state, w_next;
    logic        r_i_ram, r_i_err, r_d_valid, r_d_ram, r_d_err, r_err;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        w_i_oor, w_d_oor, w_d_partial, w_d_win, w_i_gnt, w_d_gnt;

    assign w_i_oor     = {2'b00, instr_addr_i[31:2]} >= MEM_WORDS;
    assign w_d_oor     = {2'b00, data_addr_i[31:2]} >= MEM_WORDS;
    assign w_d_partial = data_we_i && data_be_i != 4'h0 && data_be_i != 4'hF;

`ifdef RAM_ARB_RR_EN
    logic r_last_data;
    assign w_d_win = data_req_i && !(instr_req_i && r_last_data);
    // Remember which port won the most recent grant so ties alternate
    always_ff @(posedge clk) begin
        if (rst) r_last_data <= 1'b0;
        else if (w_d_gnt || w_i_gnt) r_last_data <= w_d_gnt;
    end
`else
    assign w_d_win = data_req_i;
`endif

    // Grant selection, RAM command and next state; reset suppresses everything including an in-flight RMW write
    always_comb begin
        w_next     = r_state;
        w_i_gnt    = 1'b0;
        w_d_gnt    = 1'b0;
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_di_o   = '0;
        if (!rst && r_state == RMW_WR) begin
            ram_en_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = r_addr;
            ram_di_o   = merge_bytes(ram_dout_i, r_wdata, r_be);
            w_next     = ARB;
        end else if (!rst && w_d_win) begin
            w_d_gnt    = 1'b1;
            ram_en_o   = !w_d_oor && (!data_we_i || data_be_i != 4'h0);
            ram_we_o   = !w_d_oor && data_we_i && data_be_i == 4'hF;
            ram_addr_o = data_addr_i;
            ram_di_o   = data_wdata_i;
            w_next     = (!w_d_oor && w_d_partial) ? RMW_WR : ARB;
        end else if (!rst && instr_req_i) begin
            w_i_gnt    = 1'b1;
            ram_en_o   = !w_i_oor;
            ram_addr_o = instr_addr_i;
        end
    end

    // State, response-source flags, sticky error and RMW operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB;
            r_i_ram   <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_ram   <= 1'b0;
            r_d_err   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            r_state   <= w_next;
            r_i_ram   <= w_i_gnt && !w_i_oor;
            r_i_err   <= w_i_gnt && w_i_oor;
            r_d_valid <= (w_d_gnt && !(w_d_partial && !w_d_oor)) || r_state == RMW_WR;
            r_d_ram   <= w_d_gnt && !data_we_i && !w_d_oor;
            r_d_err   <= w_d_gnt && !data_we_i && w_d_oor;
            r_err     <= r_err || (w_i_gnt && w_i_oor) || (w_d_gnt && w_d_oor);
            if (w_d_gnt) begin
                r_addr  <= data_addr_i;
                r_wdata <= data_wdata_i;
                r_be    <= data_be_i;
            end
        end
    end

    assign instr_gnt_o    = w_i_gnt;
    assign data_gnt_o     = w_d_gnt;
    assign instr_rvalid_o = r_i_ram || r_i_err;
    assign instr_rdata_o  = r_i_ram ? ram_dout_i : (r_i_err ? ERR_RDATA : '0);
    assign data_rvalid_o  = r_d_valid;
    assign data_rdata_o   = r_d_ram ? ram_dout_i : (r_d_err ? ERR_RDATA : '0);
    assign err_o          = r_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed checks of ram_port_arbiter against a word-array memory model
module tb_ram_port_arbiter;

`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        ram_en_o, ram_we_o, err_o;
    logic [31:0] ram_addr_o, ram_di_o;
    logic [31:0] ram_dout_i = '0;
    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [31:0] ref_mem [1024] = '{default: 32'h0};
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_di_o(ram_di_o), .ram_dout_i(ram_dout_i), .err_o(err_o)
    );

    // No-change single-port RAM: output register holds its value during writes
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o[11:2]] <= ram_di_o;
            else ram_dout_i <= mem[ram_addr_o[11:2]];
        end
    end

    function automatic logic [31:0] model_store(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd,
                           output logic g, output logic [31:0] rd, output int lat);
        data_req_i = 1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wd;
        #1;
        g = data_gnt_o;
        step();
        data_req_i = 0;
        lat = 1;
        while (!data_rvalid_o && lat < 8) begin
            step();
            lat++;
        end
        rd = data_rdata_o;
        if (!data_rvalid_o) lat = -1;
    endtask

    task automatic do_instr(input logic [31:0] addr, output logic g, output logic [31:0] rd, output int lat);
        instr_req_i = 1; instr_addr_i = addr;
        #1;
        g = instr_gnt_o;
        step();
        instr_req_i = 0;
        lat = 1;
        while (!instr_rvalid_o && lat < 8) begin
            step();
            lat++;
        end
        rd = instr_rdata_o;
        if (!instr_rvalid_o) lat = -1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        instr_req_i = 1; data_req_i = 1;
        step();
        tests++; if ({instr_gnt_o, data_gnt_o, ram_en_o, ram_we_o} !== 4'b0) begin fails++; $display("FAIL reset_gnt got %b exp 0000", {instr_gnt_o, data_gnt_o, ram_en_o, ram_we_o}); end
        step();
        rst = 0;
        idle();
        #1;
        tests++; if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, err_o, ram_en_o, ram_we_o} !== '0)
            begin fails++; $display("FAIL reset_out got %b/%b/%h/%h/%b exp all zero", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, err_o); end
    endtask

    task automatic test_full_store();
        logic g; logic [31:0] rd; int lat;
        do_data(1, 4'hF, 32'h10, 32'h11223344, g, rd, lat);
        ref_mem[4] = 32'h11223344;
        tests++; if ({g, lat, rd} !== {1'b1, 32'd1, 32'h0}) begin fails++; $display("FAIL full_store got g=%b lat=%0d rd=%h exp g=1 lat=1 rd=0", g, lat, rd); end
        do_instr(32'h10, g, rd, lat);
        tests++; if ({g, lat, rd} !== {1'b1, 32'd1, ref_mem[4]}) begin fails++; $display("FAIL full_store_rd got g=%b lat=%0d rd=%h exp rd=%h", g, lat, rd, ref_mem[4]); end
    endtask

    task automatic test_rmw();
        logic g; logic [31:0] rd, exp_w; int lat;
        do_data(1, 4'hF, 32'h20, 32'hAABBCCDD, g, rd, lat);
        ref_mem[8] = 32'hAABBCCDD;
        exp_w = model_store(ref_mem[8], 32'h00110022, 4'b0101);
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0101; data_addr_i = 32'h20; data_wdata_i = 32'h00110022;
        #1;
        tests++; if ({data_gnt_o, ram_en_o, ram_we_o} !== 3'b110) begin fails++; $display("FAIL rmw_grant got gnt/en/we=%b exp 110", {data_gnt_o, ram_en_o, ram_we_o}); end
        step();
        data_req_i = 0;
        instr_req_i = 1; instr_addr_i = 32'h20;
        #1;
        tests++; if ({instr_gnt_o, data_gnt_o, data_rvalid_o} !== 3'b000) begin fails++; $display("FAIL rmw_nogrant got ig/dg/rv=%b exp 000", {instr_gnt_o, data_gnt_o, data_rvalid_o}); end
        tests++; if ({ram_en_o, ram_we_o, ram_di_o} !== {2'b11, exp_w}) begin fails++; $display("FAIL rmw_write got en/we=%b di=%h exp 11 %h", {ram_en_o, ram_we_o}, ram_di_o, exp_w); end
        ref_mem[8] = exp_w;
        step();
        tests++; if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'h0}) begin fails++; $display("FAIL rmw_rvalid got %b %h exp 1 0", data_rvalid_o, data_rdata_o); end
        tests++; if (instr_gnt_o !== 1'b1) begin fails++; $display("FAIL rmw_after_gnt got %b exp 1", instr_gnt_o); end
        step();
        instr_req_i = 0;
        tests++; if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, 32'hAA11CC22}) begin fails++; $display("FAIL rmw_readback got %b %h exp 1 aa11cc22", instr_rvalid_o, instr_rdata_o); end
    endtask

    task automatic test_contention();
        logic last_d, exp_d;
        do_reset();
        last_d = 0;
        instr_req_i = 1; instr_addr_i = 32'h10;
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_d = RR ? !last_d : 1'b1;
            last_d = exp_d;
            tests++; if ({data_gnt_o, instr_gnt_o} !== {exp_d, !exp_d}) begin fails++; $display("FAIL contention[%0d] got d/i=%b exp %b", k, {data_gnt_o, instr_gnt_o}, {exp_d, !exp_d}); end
            step();
        end
        idle();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic g; logic [31:0] rd; int lat;
        for (int k = 0; k < 3; k++) begin
            ref_mem[k] = $urandom;
            do_data(1, 4'hF, 32'(k * 4), ref_mem[k], g, rd, lat);
        end
        for (int k = 0; k < 4; k++) begin
            instr_req_i = k < 3;
            instr_addr_i = 32'(k * 4);
            #1;
            if (k < 3) begin
                tests++; if (instr_gnt_o !== 1'b1) begin fails++; $display("FAIL b2b_gnt[%0d] got %b exp 1", k, instr_gnt_o); end
            end
            if (k > 0) begin
                tests++; if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, ref_mem[k-1]}) begin fails++; $display("FAIL b2b_data[%0d] got %b %h exp 1 %h", k, instr_rvalid_o, instr_rdata_o, ref_mem[k-1]); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_oor();
        logic g; logic [31:0] rd; int lat;
        do_reset();
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_err_init got %b exp 0", err_o); end
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h00001000;
        #1;
        tests++; if ({data_gnt_o, ram_en_o} !== 2'b10) begin fails++; $display("FAIL oor_noaccess got gnt/en=%b exp 10", {data_gnt_o, ram_en_o}); end
        step();
        data_req_i = 0;
        tests++; if ({data_rvalid_o, data_rdata_o, err_o} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin fails++; $display("FAIL oor_resp got %b %h err=%b exp 1 deadbeef 1", data_rvalid_o, data_rdata_o, err_o); end
        do_instr(32'hFFFF_FFF0, g, rd, lat);
        tests++; if ({g, lat, rd} !== {1'b1, 32'd1, 32'hDEADBEEF}) begin fails++; $display("FAIL oor_instr got g=%b lat=%0d rd=%h exp 1 1 deadbeef", g, lat, rd); end
        do_instr(32'h10, g, rd, lat);
        tests++; if ({err_o, rd} !== {1'b1, ref_mem[4]}) begin fails++; $display("FAIL oor_sticky got err=%b rd=%h exp 1 %h", err_o, rd, ref_mem[4]); end
        do_reset();
        #1;
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_clear got %b exp 0", err_o); end
    endtask

    task automatic test_rst_rmw();
        logic g; logic [31:0] rd; int lat;
        ref_mem[16] = 32'h12345678;
        do_data(1, 4'hF, 32'h40, ref_mem[16], g, rd, lat);
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h40; data_wdata_i = 32'h0000FFFF;
        step();
        data_req_i = 0;
        rst = 1;
        #1;
        tests++; if ({ram_en_o, ram_we_o} !== 2'b00) begin fails++; $display("FAIL rst_rmw_we got en/we=%b exp 00", {ram_en_o, ram_we_o}); end
        step();
        rst = 0;
        tests++; if (data_rvalid_o !== 1'b0) begin fails++; $display("FAIL rst_rmw_rv0 got %b exp 0", data_rvalid_o); end
        step();
        tests++; if (data_rvalid_o !== 1'b0) begin fails++; $display("FAIL rst_rmw_rv1 got %b exp 0", data_rvalid_o); end
        do_instr(32'h40, g, rd, lat);
        tests++; if ({g, lat, rd} !== {1'b1, 32'd1, ref_mem[16]}) begin fails++; $display("FAIL rst_rmw_word got g=%b lat=%0d rd=%h exp 1 1 %h", g, lat, rd, ref_mem[16]); end
    endtask

    task automatic test_random();
        logic g; logic [31:0] rd, addr, wd, exp_rd; logic [3:0] be; int lat, exp_lat, kind, word; logic oor;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            word = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) word = 1024 + $urandom_range(0, 5000);
            oor = word >= 1024;
            addr = 32'(word) * 4 + 32'($urandom_range(0, 3));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            exp_lat = 1;
            exp_rd = oor ? 32'hDEADBEEF : ref_mem[word[9:0]];
            if (kind == 0) do_instr(addr, g, rd, lat);
            else if (kind == 1) do_data(0, be, addr, wd, g, rd, lat);
            else begin
                do_data(1, be, addr, wd, g, rd, lat);
                exp_rd = 0;
                if (!oor) begin
                    if (be != 4'h0 && be != 4'hF) exp_lat = 2;
                    ref_mem[word[9:0]] = model_store(ref_mem[word[9:0]], wd, be);
                end
            end
            tests++; if ({g, lat, rd} !== {1'b1, exp_lat, exp_rd})
                begin fails++; $display("FAIL random[%0d] kind=%0d addr=%h be=%h got g=%b lat=%0d rd=%h exp 1 %0d %h", i, kind, addr, be, g, lat, rd, exp_lat, exp_rd); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_full_store();
        test_rmw();
        test_contention();
        test_back_to_back();
        test_oor();
        test_rst_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port, no-change-mode, 32-bit x 1024-word testbench RAM between the core's instruction-fetch port and data port.
- Each port uses a req/gnt/rvalid handshake.
- Partial-word stores are done as a read-modify-write (RMW), because the RAM has no byte enables.
- Sits between the core's memory interfaces and the RAM model in the testbench top.

Parameters:
- MEM_WORDS, 1024, number of RAM words; word index = addr[31:2].
- ERR_RDATA, 32'hDEADBEEF, read data returned for out-of-range accesses.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch granted this cycle.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  32  fetch data.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  data request granted this cycle.
- data_rvalid_o  out  1  load data valid or store complete.
- data_rdata_o  out  32  load data.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM byte address.
- ram_di_o  out  32  RAM write data.
- ram_dout_i  in  32  RAM read data, registered one cycle after the read.
- err_o  out  1  sticky: an out-of-range access occurred.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: all gnt, rvalid, ram_en and ram_we outputs are 0; rdata outputs are 0; err_o = 0; FSM = ARB.
- Reset mid-RMW aborts the RMW with no RAM write. Pending rvalids are dropped.
- States: ARB and RMW_WR.
- ARB, granting:
  - Grant is combinational in the same cycle as req.
  - At most one gnt per cycle; the arbitration rule is given under Optional Feature.
  - The requester holds its address/data stable from req until gnt.
- Granted read (instr, or data with we=0):
  - Same cycle: ram_en=1, ram_we=0, ram_addr_o = request address.
  - Next cycle: rvalid=1 and rdata = ram_dout_i.
  - Back-to-back reads give one grant per cycle.
- Granted full store (be=4'hF):
  - Same cycle: ram_en=1, ram_we=1, ram_di_o = wdata.
  - Next cycle: data_rvalid_o=1, data_rdata_o=0.
- Granted partial store (be not 0, not F):
  - Grant cycle: RAM read of the word is issued. addr, be and wdata are latched. Next state RMW_WR.
  - RMW_WR cycle: ram_en=1, ram_we=1. Merged word = wdata bytes where be=1, ram_dout_i bytes elsewhere. No grants in this cycle. Next state ARB.
  - data_rvalid_o=1 in the cycle after RMW_WR, so store latency is 2.
- Store with be=0: granted; no RAM access; data_rvalid_o=1 next cycle.
- Out of range (addr[31:2] >= MEM_WORDS):
  - Granted normally; no RAM access.
  - rvalid next cycle; reads return ERR_RDATA.
  - err_o set, and cleared only by rst.
- addr[1:0] is ignored (word-aligned access).
- rdata outputs are 0 whenever the matching rvalid is 0.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-granted flag updates on each grant.
  - On simultaneous requests, the port not granted last wins.
  - After reset the flag is "instr", so data wins the first tie.
- Undefined: fixed priority, data over instr; instr can starve while data_req_i is held high.

Decomposition:
- Package ram_arb_pkg holds:
  - the state typedef (ARB, RMW_WR);
  - MEM_WORDS and ERR_RDATA defaults;
  - the byte-merge function (old word, new word, be) -> merged word.
- No sub-module: the block is one FSM plus response registers.

Test Plan:
- Data store 0x00000010 wdata 0x11223344 be F, then instr read 0x10 -> data_rvalid_o after 1 cycle; instr_rdata_o = 0x11223344 one cycle after instr_gnt_o.
- Word 0x20 holds 0xAABBCCDD; data store be 4'b0101, wdata 0x00110022 -> rvalid 2 cycles after grant; no grants in RMW_WR; readback = 0xAA11CC22.
- Both req high for 4 cycles:
  - fixed priority: 4 data grants;
  - RAM_ARB_RR_EN: grants data, instr, data, instr.
- Back-to-back instr reads of 0x0, 0x4, 0x8 -> gnt held 3 cycles; rvalid 3 consecutive cycles with matching data.
- Data read 0x00001000 (word 1024) -> no ram_en; rdata = 0xDEADBEEF; err_o = 1 and stays set until rst.
- rst asserted in the RMW_WR cycle -> ram_we_o = 0 in that cycle, target word unchanged, no data_rvalid_o, FSM in ARB.
